loopback_fifo: RTL
==================

# loopback_fifo

Per-channel elastic buffer that sits between the `usb_cdc` OUT bulk streams and the `usb_cdc` IN bulk streams of the multi-channel loopback design. It consumes bytes from `out_data_o`/`out_valid_o` and returns them unchanged, in order, on `in_data_i`/`in_valid_i`. Each channel gets an independent FIFO so that a host not reading one channel never stalls the others. Per-channel fill level and flush are exposed for status and debug.

## Interface
- `CHANNELS`, default 7: number of independent byte channels.
- `DEPTH`, default 16: FIFO depth in bytes per channel; must be a power of two, ≥ 2.
- `LW`, default $clog2(DEPTH)+1: level width (derived; do not override).

One clock; reset is synchronous and active-high.

- `clk_i`  input  1  app clock, shared with `usb_cdc` `app_clk_i`.
- `rst_i`  input  1  synchronous, active-high reset.
- `s_data_i`  input  8*CHANNELS  write bytes; channel c occupies bits [8c+7:8c]. Driven from `usb_cdc` `out_data_o`.
- `s_valid_i`  input  CHANNELS  write valid per channel.
- `s_ready_o`  output  CHANNELS  write ready per channel. Drives `usb_cdc` `out_ready_i`.
- `m_data_o`  output  8*CHANNELS  read bytes, same packing. Drives `usb_cdc` `in_data_i`.
- `m_valid_o`  output  CHANNELS  read valid per channel.
- `m_ready_i`  input  CHANNELS  read ready per channel. Driven from `usb_cdc` `in_ready_o`.
- `flush_i`  input  CHANNELS  synchronous per-channel discard.
- `level_o`  output  LW*CHANNELS  bytes stored per channel; channel c occupies bits [LW*c+LW-1:LW*c].

## Operation
- Per channel c, the block holds:
  - a DEPTH×8 storage array, not reset;
  - `wr_ptr` and `rd_ptr` of $clog2(DEPTH) bits, wrapping modulo DEPTH;
  - `count` of LW bits, range 0..DEPTH.
- Handshakes:
  - Push when `s_valid_i[c] & s_ready_o[c]`: write `mem[wr_ptr]`, then `wr_ptr+1`.
  - Pop when `m_valid_o[c] & m_ready_i[c]`: `rd_ptr+1`.
- `count` update:
  - push only: +1;
  - pop only: −1;
  - both, or neither: unchanged.
- `s_ready_o[c] = ~rst_i & ~flush_i[c] & (count != DEPTH)`. It does not depend on `m_ready_i`, so there is no combinational path from read side to write side.
- `m_valid_o[c] = (count != 0)`. It does not depend on `s_valid_i`.
- `m_data_o[c]`:
  - `mem[rd_ptr]` when `count != 0`;
  - 8'h00 when empty (forced, for deterministic checking).
- `level_o[c] = count`, registered.
- Flush, when `flush_i[c]` is high:
  - next cycle: `wr_ptr = rd_ptr = count = 0`;
  - flush takes priority over a same-cycle pop;
  - a pop that handshakes in the flush cycle is still delivered to the consumer;
  - `s_ready_o[c]` is low during flush, so no push is lost.
- Boundary conditions:
  - Full (`count == DEPTH`): a pop still occurs; no push in that cycle; `s_ready_o` rises the next cycle.
  - Empty: a push still occurs; no pop in that cycle.
  - Pointer wrap DEPTH−1 → 0: transparent; byte order is preserved across the wrap.
- Channels are fully independent: no arbitration and no shared state.

## Timing
- Reset values, at the first edge with `rst_i` high and held while high:
  - `count`, `wr_ptr`, `rd_ptr` = 0;
  - `m_valid_o` = 0, `m_data_o` = 0, `level_o` = 0;
  - `s_ready_o` = 0 while `rst_i` is high, all ones the cycle after `rst_i` falls.
- Reset mid-operation: all stored bytes are discarded. The first byte pushed after reset is the first byte popped.
- Latency: a byte pushed at edge N is visible on `m_data_o`/`m_valid_o` after edge N, i.e. in cycle N+1. There is no fall-through within the same cycle.
- Throughput: one push and one pop per channel per cycle, sustained, at any fill level 1..DEPTH−1.
- `level_o` reflects handshakes completed at the preceding edge.

## Test plan
- Reset, then a single byte on channel 0 (0xA5 pushed at cycle 5):
  - `m_valid_o[0] = 1` and `m_data_o[7:0] = 0xA5` at cycle 6;
  - `level_o` ch0 = 1;
  - with `m_ready_i[0] = 1`, ch0 is empty at cycle 7 and `m_data_o = 0`.
- Fill channel 3 with 0x00..0x0F while `m_ready_i[3] = 0`:
  - after 16 pushes, `s_ready_o[3] = 0` and `level_o` ch3 = 16;
  - one pop then returns 0x00, and `s_ready_o[3] = 1` the next cycle.
- Wrap and streaming on channel 6 with both sides always ready: stream 0x00..0x3F (64 bytes) → output is identical and in order, `level_o` ch6 never exceeds 1, and there are no gaps after the first byte.
- Simultaneous push and pop at level 8 on channel 2 → level stays 8 and the output byte is the oldest one.
- Channel isolation: stall channel 1 full (`m_ready_i[1] = 0`) while streaming channel 4 → channel 4 throughput is one byte per cycle and channel 1 contents are intact afterwards.
- Flush and reset:
  - flush channel 5 at level 5 with a same-cycle pop → popped byte delivered; next cycle level = 0, `m_valid_o[5] = 0`, `s_ready_o[5]` low only in the flush cycle;
  - repeat with `rst_i` pulsed for 1 cycle at level 9 → all outputs equal their reset values.

Source files
------------

// File: rtl/loopback_fifo.sv
// Per-channel byte FIFO returning each OUT stream unchanged on its IN stream; one-cycle push-to-pop latency.
// Backpressure: s_ready drops only when the channel is full, flushing or in reset; channels never stall each other.
module loopback_fifo #(
  parameter int CHANNELS = 7,
  parameter int DEPTH    = 16,
  parameter int LW       = $clog2(DEPTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [8*CHANNELS-1:0]  s_data_i,
  input  logic [CHANNELS-1:0]    s_valid_i,
  output logic [CHANNELS-1:0]    s_ready_o,
  output logic [8*CHANNELS-1:0]  m_data_o,
  output logic [CHANNELS-1:0]    m_valid_o,
  input  logic [CHANNELS-1:0]    m_ready_i,
  input  logic [CHANNELS-1:0]    flush_i,
  output logic [LW*CHANNELS-1:0] level_o
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          push;
    logic          pop;

    // Ready never looks at m_ready_i, so read and write sides stay decoupled.
    assign s_ready_o[c]         = ~rst_i & ~flush_i[c] & (count_q != FULL_LVL);
    assign m_valid_o[c]         = (count_q != '0);
    assign m_data_o[8*c +: 8]   = m_valid_o[c] ? mem[rd_ptr_q] : 8'h00;
    assign level_o[LW*c +: LW]  = count_q;

    assign push = s_valid_i[c] & s_ready_o[c];
    assign pop  = m_valid_o[c] & m_ready_i[c];

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i[c]) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end else begin
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + LW'(1);
        else if (pop && !push) count_d = count_q - LW'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    // Storage is intentionally left unreset; count gates every read.
    always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr_q] <= s_data_i[8*c +: 8];
    end
  end

endmodule
